// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and status codes for the I2C command sequencer
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } seq_state_t;

  localparam logic [3:0] ERR_OK      = 4'h0;
  localparam logic [3:0] ERR_LEN     = 4'hE;
  localparam logic [3:0] ERR_TIMEOUT = 4'hF;

endpackage

// File: rtl/i2c_byte_fifo.sv
// rtl/i2c_byte_fifo.sv - 8-bit synchronous byte FIFO with full/empty/count
module i2c_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // a pop frees the slot this cycle, so a push while full is still taken
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// rtl/i2c_cmd_sequencer.sv - packs host transactions into i2c_master commands and returns responses
// Optional watchdog on ISSUE/WAIT enabled by I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hdr_valid,
  output logic                    hdr_ready,
  input  logic [6:0]              hdr_slave,
  input  logic                    hdr_rw,
  input  logic [7:0]              hdr_reg,
  input  logic [7:0]              hdr_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [7:0]              wr_byte,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0]              rsp_status,
  output logic [7:0]              rsp_data,
  output logic                    m_valid_cmd,
  output logic [15:0]             m_addr,
  output logic [DATA_WIDTH*8-1:0] m_data_in,
  output logic [7:0]              m_data_len,
  input  logic                    m_accept,
  input  logic                    m_done,
  input  logic [3:0]              m_error,
  input  logic [7:0]              m_data_out
);

  localparam logic [7:0] MAX_LEN = 8'(DATA_WIDTH);

  seq_state_t state, state_nxt;
  logic       rw_q;
  logic [7:0] len_q;
  logic [7:0] idx;
  logic       bad_len;
  logic       pop;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic       tmo_hit;
  logic       unused_sig;

  assign bad_len     = !rw_q && (len_q == 8'd0 || len_q > MAX_LEN);
  assign pop         = (state == S_LOAD) && !fifo_empty;
  assign wr_ready    = !fifo_full || pop;
  assign push        = wr_valid && wr_ready;
  assign hdr_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign m_valid_cmd = (state == S_ISSUE);

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_byte),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // count stays zero outside ISSUE/WAIT, so it is already cleared on ISSUE entry
  always_ff @(posedge clk) begin
    if (rst || !(state == S_ISSUE || state == S_WAIT)) tmo_cnt <= '0;
    else                                                 tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit    = (state == S_ISSUE || state == S_WAIT) && (tmo_cnt == 32'(TIMEOUT_CYC - 1));
  assign unused_sig = ^fifo_count;
`else
  assign tmo_hit    = 1'b0;
  assign unused_sig = ^{fifo_count, 32'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hdr_valid) state_nxt = S_CHECK;
      S_CHECK: begin
        if (bad_len)   state_nxt = S_RESP;
        else if (rw_q) state_nxt = S_ISSUE;
        else           state_nxt = S_LOAD;
      end
      S_LOAD:  if (pop && idx == len_q - 8'd1) state_nxt = S_ISSUE;
      S_ISSUE: if (m_accept) state_nxt = S_WAIT;
      S_WAIT:  if (m_done) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (tmo_hit) state_nxt = S_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q       <= 1'b0;
      len_q      <= '0;
      idx        <= '0;
      m_addr     <= '0;
      m_data_in  <= '0;
      m_data_len <= '0;
      rsp_status <= ERR_OK;
      rsp_data   <= '0;
    end else begin
      case (state)
        S_IDLE: if (hdr_valid) begin
          m_addr    <= {hdr_slave, hdr_rw, hdr_reg};
          rw_q      <= hdr_rw;
          len_q     <= hdr_len;
          idx       <= '0;
          m_data_in <= '0;
        end
        S_CHECK: begin
          if (bad_len) begin
            rsp_status <= ERR_LEN;
            rsp_data   <= '0;
          end else begin
            m_data_len <= rw_q ? 8'd1 : len_q;
          end
        end
        S_LOAD: if (pop) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (idx == 8'(i)) m_data_in[i*8 +: 8] <= fifo_dout;
          end
          idx <= idx + 8'd1;
        end
        S_WAIT: if (m_done) begin
          rsp_status <= m_error;
          rsp_data   <= rw_q ? m_data_out : 8'd0;
        end
        default: ;
      endcase
      // a completion landing on the watchdog's last cycle still reports the master's status
      if (tmo_hit && !(state == S_WAIT && m_done)) begin
        rsp_status <= ERR_TIMEOUT;
        rsp_data   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb/tb_i2c_cmd_sequencer.sv - self-checking bench for i2c_cmd_sequencer
module tb_i2c_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid, hdr_ready, hdr_rw;
  logic [6:0]  hdr_slave;
  logic [7:0]  hdr_reg, hdr_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_byte;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_status;
  logic [7:0]  rsp_data;
  logic        m_valid_cmd;
  logic [15:0] m_addr;
  logic [63:0] m_data_in;
  logic [7:0]  m_data_len;
  logic        m_accept, m_done;
  logic [3:0]  m_error;
  logic [7:0]  m_data_out;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  typedef struct {
    int          npush;
    logic [63:0] pbytes;
    logic [6:0]  slave;
    logic        rw;
    logic [7:0]  rg;
    logic [7:0]  len;
    logic        bad;
    logic [3:0]  err;
    logic [7:0]  dout;
    logic [15:0] e_addr;
    logic [63:0] e_data;
    logic [7:0]  e_len;
    logic [3:0]  e_st;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vecs[6];

  i2c_cmd_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_slave(hdr_slave), .hdr_rw(hdr_rw),
    .hdr_reg(hdr_reg), .hdr_len(hdr_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_byte(wr_byte),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .m_valid_cmd(m_valid_cmd), .m_addr(m_addr), .m_data_in(m_data_in), .m_data_len(m_data_len),
    .m_accept(m_accept), .m_done(m_done), .m_error(m_error), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push one byte with no concurrent pop; the model says it is taken only below 16 entries.
  task automatic push_byte(input logic [7:0] b);
    logic exp_acc;
    exp_acc  = (q.size() < 16);
    wr_valid = 1'b1;
    wr_byte  = b;
    chk("wr_ready", wr_ready, exp_acc);
    step();
    wr_valid = 1'b0;
    if (exp_acc) q.push_back(b);
  endtask

  task automatic send_hdr(input logic [6:0] s, input logic rw, input logic [7:0] rg, input logic [7:0] len);
    int n = 0;
    while (!hdr_ready && n < 200) begin step(); n++; end
    chk("hdr_ready_wait", hdr_ready, 1'b1);
    hdr_slave = s; hdr_rw = rw; hdr_reg = rg; hdr_len = len;
    hdr_valid = 1'b1;
    step();
    hdr_valid = 1'b0;
  endtask

  task automatic wait_issue(output int lat);
    lat = 0;
    while (!m_valid_cmd && lat < 200) begin step(); lat++; end
    chk("issue_wait", m_valid_cmd, 1'b1);
  endtask

  task automatic complete(input logic [3:0] err, input logic [7:0] dout, input string tag);
    int ad, dd;
    bit inject;
    ad = $urandom_range(0, 3);
    inject = (ad > 0) && ($urandom_range(0, 1) == 1);
    for (int k = 0; k < ad; k++) begin
      if (k == 0 && inject) begin
        m_done = 1'b1; m_error = 4'h9; m_data_out = 8'hEE;
      end
      step();
      m_done = 1'b0;
      chk({tag, " hold_valid"}, m_valid_cmd, 1'b1);
    end
    m_accept = 1'b1;
    step();
    m_accept = 1'b0;
    chk({tag, " valid_drop"}, m_valid_cmd, 1'b0);
    dd = $urandom_range(0, 3);
    repeat (dd) step();
    m_done = 1'b1; m_error = err; m_data_out = dout;
    step();
    m_done = 1'b0; m_error = 4'h0; m_data_out = 8'h00;
  endtask

  task automatic resp(input logic [3:0] e_st, input logic [7:0] e_rd, input string tag);
    int n = 0;
    int rd;
    while (!rsp_valid && n < 200) begin step(); n++; end
    chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, " status"}, rsp_status, e_st);
    chk({tag, " rdata"}, rsp_data, e_rd);
    rd = $urandom_range(0, 2);
    repeat (rd) begin
      step();
      chk({tag, " rsp_hold"}, rsp_valid, 1'b1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_clear"}, rsp_valid, 1'b0);
    chk({tag, " back_idle"}, hdr_ready, 1'b1);
  endtask

  task automatic run_txn(input vec_t v, input int e_lat, input string tag);
    int lat, cnt0;
    bit seen;
    send_hdr(v.slave, v.rw, v.rg, v.len);
    if (v.bad) begin
      cnt0 = q.size();
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (m_valid_cmd) seen = 1'b1;
        if (rsp_valid) break;
        step();
      end
      chk({tag, " no_issue"}, seen, 1'b0);
      chk({tag, " fifo_kept"}, dut.u_fifo.count, cnt0);
      resp(v.e_st, v.e_rd, tag);
    end else begin
      wait_issue(lat);
      if (e_lat >= 0) chk({tag, " latency"}, lat, e_lat);
      chk({tag, " addr"}, m_addr, v.e_addr);
      chk({tag, " len"}, m_data_len, v.e_len);
      if (!v.rw) chk({tag, " data"}, m_data_in, v.e_data);
      complete(v.err, v.dout, tag);
      resp(v.e_st, v.e_rd, tag);
    end
  endtask

  // Reference: address is plain arithmetic on the header, data comes off the byte queue in order.
  task automatic model_txn(input logic [6:0] s, input logic rw, input logic [7:0] rg, input logic [7:0] len,
                           input logic [3:0] err, input logic [7:0] dout, input string tag);
    vec_t v;
    int e_lat;
    v.npush = 0; v.pbytes = '0;
    v.slave = s; v.rw = rw; v.rg = rg; v.len = len;
    v.bad = !rw && (len == 0 || len > 8);
    v.err = err; v.dout = dout;
    v.e_addr = 16'(s) * 16'd512 + 16'(rw) * 16'd256 + 16'(rg);
    v.e_len = rw ? 8'd1 : len;
    v.e_data = '0;
    if (!rw && !v.bad) begin
      for (int i = 0; i < int'(len); i++) v.e_data = v.e_data | (64'(q.pop_front()) << (8 * i));
    end
    v.e_st = v.bad ? 4'hE : err;
    v.e_rd = (v.bad || !rw) ? 8'h00 : dout;
    e_lat = rw ? 1 : int'(len) + 1;
    run_txn(v, e_lat, tag);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [63:0] exp_d;
    rst = 1'b1;
    hdr_valid = 0; hdr_slave = 0; hdr_rw = 0; hdr_reg = 0; hdr_len = 0;
    wr_valid = 0; wr_byte = 0; rsp_ready = 0;
    m_accept = 0; m_done = 0; m_error = 0; m_data_out = 0;
    step(); step();
    rst = 1'b0;

    chk("rst hdr_ready", hdr_ready, 1'b1);
    chk("rst wr_ready", wr_ready, 1'b1);
    chk("rst rsp_valid", rsp_valid, 1'b0);
    chk("rst m_valid_cmd", m_valid_cmd, 1'b0);
    chk("rst m_addr", m_addr, 16'h0);
    chk("rst m_data_in", m_data_in, 64'h0);
    chk("rst m_data_len", m_data_len, 8'h0);
    chk("rst rsp_status", rsp_status, 4'h0);
    chk("rst rsp_data", rsp_data, 8'h0);

    vecs[0] = '{2, 64'hCDAA, 7'h55, 1'b0, 8'hBB, 8'd2, 1'b0, 4'h0, 8'h00,
                16'hAABB, 64'hCDAA, 8'd2, 4'h0, 8'h00};
    vecs[1] = '{0, 64'h0, 7'h55, 1'b1, 8'h10, 8'h07, 1'b0, 4'h0, 8'h3C,
                16'hAB10, 64'h0, 8'd1, 4'h0, 8'h3C};
    vecs[2] = '{8, 64'h0807060504030201, 7'h7F, 1'b0, 8'hFF, 8'd8, 1'b0, 4'h5, 8'h77,
                16'hFEFF, 64'h0807060504030201, 8'd8, 4'h5, 8'h00};
    vecs[3] = '{0, 64'h0, 7'h00, 1'b1, 8'h00, 8'd0, 1'b0, 4'h3, 8'hA5,
                16'h0100, 64'h0, 8'd1, 4'h3, 8'hA5};
    vecs[4] = '{2, 64'h2211, 7'h12, 1'b0, 8'h34, 8'd0, 1'b1, 4'h0, 8'h00,
                16'h0, 64'h0, 8'd0, 4'hE, 8'h00};
    vecs[5] = '{0, 64'h0, 7'h12, 1'b0, 8'h34, 8'd9, 1'b1, 4'h0, 8'h00,
                16'h0, 64'h0, 8'd0, 4'hE, 8'h00};

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].npush; j++) push_byte(vecs[i].pbytes[8*j +: 8]);
      run_txn(vecs[i], vecs[i].rw ? 1 : int'(vecs[i].len) + 1, $sformatf("vec%0d", i));
      if (!vecs[i].rw && !vecs[i].bad)
        for (int j = 0; j < int'(vecs[i].len); j++) void'(q.pop_front());
    end

    for (int t = 0; t < 40; t++) begin
      logic rw;
      logic [7:0] len;
      int need, extra;
      rw = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(9, 30));
      else                           len = 8'($urandom_range(1, 8));
      need = (!rw && len >= 1 && len <= 8) ? int'(len) : 0;
      while (q.size() < need) push_byte(8'($urandom));
      extra = $urandom_range(0, 2);
      for (int k = 0; k < extra; k++) if (q.size() < 12) push_byte(8'($urandom));
      model_txn(7'($urandom), rw, 8'($urandom), len, 4'($urandom), 8'($urandom), $sformatf("rnd%0d", t));
    end

    // reset while waiting for the master: silent abort, FIFO emptied
    send_hdr(7'h33, 1'b1, 8'h44, 8'd0);
    wait_issue(lat);
    m_accept = 1'b1; step(); m_accept = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    q.delete();
    chk("wait_rst hdr_ready", hdr_ready, 1'b1);
    chk("wait_rst m_valid_cmd", m_valid_cmd, 1'b0);
    chk("wait_rst fifo", dut.u_fifo.count, 0);
    chk("wait_rst m_addr", m_addr, 16'h0);
    m_done = 1'b1; m_data_out = 8'h99; step(); m_done = 1'b0;
    seen = 1'b0;
    repeat (3) begin if (rsp_valid) seen = 1'b1; step(); end
    chk("wait_rst no_rsp", seen, 1'b0);

    // LOAD stalls on an empty FIFO, bytes trickle in 5 cycles apart
    send_hdr(7'h21, 1'b0, 8'h44, 8'd3);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin step(); if (m_valid_cmd) seen = 1'b1; end
      push_byte(8'(8'hA0 + k));
    end
    chk("stall no_early_issue", seen, 1'b0);
    wait_issue(lat);
    chk("stall latency", lat, 1);
    exp_d = 64'h0;
    for (int i = 0; i < 3; i++) exp_d = exp_d | (64'(q.pop_front()) << (8 * i));
    chk("stall data", m_data_in, exp_d);
    chk("stall addr", m_addr, 16'h4244);
    complete(4'h0, 8'h00, "stall");
    resp(4'h0, 8'h00, "stall");

    // full FIFO: overflow byte dropped, push+pop while full keeps count
    for (int k = 0; k < 16; k++) push_byte(8'($urandom));
    chk("full count", dut.u_fifo.count, 16);
    chk("full wr_ready", wr_ready, 1'b0);
    push_byte(8'hDD);
    chk("overflow count", dut.u_fifo.count, 16);
    send_hdr(7'h0A, 1'b0, 8'h5A, 8'd8);
    wr_valid = 1'b1; wr_byte = 8'h77;
    step();
    chk("full_pop wr_ready", wr_ready, 1'b1);
    step();
    wr_valid = 1'b0;
    chk("full_pop count", dut.u_fifo.count, 16);
    exp_d = 64'h0;
    for (int i = 0; i < 8; i++) exp_d = exp_d | (64'(q.pop_front()) << (8 * i));
    q.push_back(8'h77);
    wait_issue(lat);
    chk("full_pop data", m_data_in, exp_d);
    complete(4'h2, 8'h00, "full_pop");
    resp(4'h2, 8'h00, "full_pop");
    model_txn(7'h0B, 1'b0, 8'h01, 8'd8, 4'h0, 8'h00, "drain8");
    model_txn(7'h0C, 1'b0, 8'h02, 8'd1, 4'h0, 8'h00, "drain1");
    chk("drained", dut.u_fifo.count, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
    send_hdr(7'h66, 1'b1, 8'h01, 8'd0);
    wait_issue(lat);
    lat = 0;
    while (m_valid_cmd && lat < 200) begin step(); lat++; end
    chk("tmo cycles", lat, 50);
    resp(4'hF, 8'h00, "tmo");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
